tlp_wr_arbiter: RTL and testbench
=================================

# tlp_wr_arbiter

Round-robin scheduler that shares one downstream TLP packetizer between several AXI write-decoder chunk streams. Each requester presents a decoded MemWr chunk: address, DW length, BDF and up to four 256-bit beats of payload. The arbiter gates grants on PCIe posted-header and posted-data flow-control credits, latches the winner into a single output register, and holds it until the packetizer accepts it.

## Interface
Parameters:
- N_REQ, 2: number of requesters (2..8).
- ADDR_WIDTH, 32: request address width.
- DATA_WIDTH, 1024: payload width per request (4 beats × 256 b).
- CREDIT_WIDTH, 8: width of credit counters and the return input.
- PH_CREDIT_INIT, 8: posted-header credits after reset; also the saturation ceiling.
- PD_CREDIT_INIT, 64: posted-data credits after reset (1 credit = 4 DW); also the saturation ceiling.

Ports:
- clk, in, 1: single clock; all logic is rising-edge.
- rst_n, in, 1: synchronous active-low reset.
- req_valid, in, N_REQ: per-requester request valid.
- req_ready, out, N_REQ: per-requester accept; one-hot or zero.
- req_addr, in, N_REQ*ADDR_WIDTH: packed addresses; requester i occupies slice i.
- req_length, in, N_REQ*8: packed payload lengths in DW (0..32).
- req_bdf, in, N_REQ*16: packed requester BDFs.
- req_wdata, in, N_REQ*DATA_WIDTH: packed payloads.
- out_valid, out, 1: latched request available for the packetizer.
- out_ready, in, 1: packetizer accept.
- out_addr / out_length / out_bdf / out_wdata, out, ADDR_WIDTH / 8 / 16 / DATA_WIDTH: latched request fields.
- out_grant_id, out, $clog2(N_REQ): index of the requester held in the output register.
- ph_credit_return, in, 1: returns one posted-header credit in the current cycle.
- pd_credit_return, in, CREDIT_WIDTH: number of posted-data credits returned in the current cycle.
- ph_credit_avail / pd_credit_avail, out, CREDIT_WIDTH: current credit counters.

## Operation
- The FSM has two states: IDLE and SEND.
- **IDLE:**
  - A requester i is eligible when req_valid[i] = 1, ph_avail ≥ 1 and pd_avail ≥ need_i.
  - need_i = ceil(req_length_i / 4), computed as (len + 3) >> 2. A length of 0 needs 0 data credits.
  - The winner is the first eligible index searched from (rr_ptr + 1) mod N_REQ upward, with wrap.
  - With a winner, req_ready[winner] = 1 combinationally in the same cycle.
  - On that edge: the winner's fields are registered into the out_* registers, out_grant_id ← winner, rr_ptr ← winner, credits are consumed, and the state moves to SEND.
- **Ineligible requesters:** requesters blocked by credits are skipped; lower-need requests may pass them. No head-of-line ordering exists across requesters.
- **SEND:**
  - out_valid = 1 and all out_* fields are stable.
  - req_ready = 0.
  - When out_valid && out_ready, the state returns to IDLE.
- **Credit counters:** every cycle, avail_next = avail − consumed + returned.
  - Grant and return in the same cycle are both applied.
  - The result is clamped to the INIT ceiling; excess returns are dropped.
  - The counters never underflow, because the eligibility check guarantees it.
- **Requester contract:** requesters must hold all fields stable while req_valid = 1 and not yet accepted. The arbiter does not check this.

## Timing
- Values during reset:
  - state = IDLE, out_valid = 0, req_ready = 0.
  - out_addr, out_length, out_bdf, out_wdata and out_grant_id = 0.
  - rr_ptr = N_REQ−1, so requester 0 has first priority.
  - ph_avail = PH_CREDIT_INIT, pd_avail = PD_CREDIT_INIT.
- Latency: grant in cycle t (req_ready high) gives out_valid = 1 in cycle t+1, at the earliest.
- Back-to-back requests are never granted: after the out accept edge, out_valid = 0 for at least one cycle (IDLE). Peak throughput is 1 request per 2 cycles.
- Credit outputs reflect registered counters. A return in cycle t is visible and usable for eligibility in cycle t+1.
- Reset asserted mid-SEND: the held request is discarded and out_valid drops at the reset edge. Credits reinitialise; the downstream must also be reset.
- A change on req_valid while in SEND has no effect until IDLE.

## Configuration
- TLP_ARB_CREDIT_CHECK_EN defined:
  - Eligibility includes the credit conditions.
  - Counters consume and return as above.
  - ph/pd_credit_avail are driven from the counters.
- Not defined:
  - Eligibility is req_valid only.
  - Counter logic is removed.
  - ph_credit_avail and pd_credit_avail are tied to PH_CREDIT_INIT and PD_CREDIT_INIT.
  - The credit return inputs are ignored.

## Test plan
- Reset release, requester 0 valid (addr 0x1000, len 32), out_ready = 1:
  - req_ready[0] is high in the first IDLE cycle; out_valid rises the next cycle with out_addr = 0x1000 and out_grant_id = 0.
  - Afterwards pd_avail = 56 and ph_avail = 7.
- Both requesters continuously valid, len 8, out_ready = 1: grants alternate 0, 1, 0, 1 with one request every 2 cycles.
- out_ready held 0 for 5 cycles in SEND: out_valid stays 1 with fields unchanged and req_ready = 0. Requester 1 is granted only after the accept.
- Credit starvation, with the macro defined:
  - Setup: pd_avail = 4; req 0 len 32 (need 8); req 1 len 8 (need 2).
  - req 1 is granted and req 0 is skipped.
  - pd_credit_return = 6 (pd_avail 2 → 8) lets req 0 be granted in the following IDLE.
- Grant and return in the same cycle: pd_avail = 10, grant needing 8, return 5 gives 7. Returning 100 at full credits clamps to 64.
- rst_n = 0 during SEND: the next cycle shows out_valid = 0, credits at INIT and rr_ptr = N_REQ−1.

Source files
------------

// File: rtl/tlp_wr_arbiter.sv
// Round-robin arbiter sharing one TLP packetizer among N_REQ MemWr chunk requesters.
// Latency: req_ready in cycle t, out_valid from cycle t+1; at most one request every two cycles.
// Backpressure: output register holds until out_ready; req_ready stays low while it is occupied.
// Build option: define TLP_ARB_CREDIT_CHECK_EN to gate grants on posted header/data credits.
module tlp_wr_arbiter #(
  parameter int N_REQ          = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 1024,
  parameter int CREDIT_WIDTH   = 8,
  parameter int PH_CREDIT_INIT = 8,
  parameter int PD_CREDIT_INIT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*8-1:0]            req_length,
  input  logic [N_REQ*16-1:0]           req_bdf,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic [7:0]                    out_length,
  output logic [15:0]                   out_bdf,
  output logic [DATA_WIDTH-1:0]         out_wdata,
  output logic [$clog2(N_REQ)-1:0]      out_grant_id,
  input  logic                          ph_credit_return,
  input  logic [CREDIT_WIDTH-1:0]       pd_credit_return,
  output logic [CREDIT_WIDTH-1:0]       ph_credit_avail,
  output logic [CREDIT_WIDTH-1:0]       pd_credit_avail
);

  localparam int IDW = $clog2(N_REQ);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            length;
    logic [15:0]           bdf;
    logic [DATA_WIDTH-1:0] wdata;
  } wr_req_t;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   grant_id_q;
  wr_req_t          out_q;
  wr_req_t          win_req;
  logic [N_REQ-1:0] eligible;
  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic             grant;
  int               cand;

`ifdef TLP_ARB_CREDIT_CHECK_EN
  // Sum width leaves headroom for avail + return before clamping and for (len + 3).
  localparam int SW = CREDIT_WIDTH + 2;

  logic [CREDIT_WIDTH-1:0] ph_avail_q, pd_avail_q;
  logic [CREDIT_WIDTH-1:0] ph_next, pd_next;
  logic [SW-1:0]           ph_sum, pd_sum;
  logic [SW-1:0]           need [N_REQ];

  // Data-credit need per requester (ceil of DW/4) and credit-qualified eligibility
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      need[i]     = (SW'(req_length[i*8 +: 8]) + SW'(3)) >> 2;
      eligible[i] = req_valid[i] && (ph_avail_q != '0) && (SW'(pd_avail_q) >= need[i]);
    end
  end

  // Next credit values: consume on grant, add returns, clamp at the reset ceiling
  always_comb begin
    ph_sum = SW'(ph_avail_q) + SW'(ph_credit_return) - (grant ? SW'(1) : SW'(0));
    pd_sum = SW'(pd_avail_q) + SW'(pd_credit_return) - (grant ? need[win_idx] : SW'(0));
    ph_next = (ph_sum > SW'(PH_CREDIT_INIT)) ? CREDIT_WIDTH'(PH_CREDIT_INIT) : ph_sum[CREDIT_WIDTH-1:0];
    pd_next = (pd_sum > SW'(PD_CREDIT_INIT)) ? CREDIT_WIDTH'(PD_CREDIT_INIT) : pd_sum[CREDIT_WIDTH-1:0];
  end

  // Credit counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph_avail_q <= CREDIT_WIDTH'(PH_CREDIT_INIT);
      pd_avail_q <= CREDIT_WIDTH'(PD_CREDIT_INIT);
    end else begin
      ph_avail_q <= ph_next;
      pd_avail_q <= pd_next;
    end
  end

  assign ph_credit_avail = ph_avail_q;
  assign pd_credit_avail = pd_avail_q;
`else
  // Without credit gating any valid requester may win
  always_comb begin
    eligible = req_valid;
  end

  assign ph_credit_avail = CREDIT_WIDTH'(PH_CREDIT_INIT);
  assign pd_credit_avail = CREDIT_WIDTH'(PD_CREDIT_INIT);

  // Credit returns have no consumer in this build.
  logic unused_credit_return;
  assign unused_credit_return = ^{ph_credit_return, pd_credit_return};
`endif

  // Round-robin search from the slot after the last winner, wrapping once
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % N_REQ;
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = IDW'(cand);
      end
    end
  end

  // Select the winning requester's fields
  always_comb begin
    win_req.addr   = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    win_req.length = req_length[win_idx*8 +: 8];
    win_req.bdf    = req_bdf[win_idx*16 +: 16];
    win_req.wdata  = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and handshake outputs; no grant while reset is asserted
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    req_ready = '0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found && rst_n) begin
          grant              = 1'b1;
          req_ready[win_idx] = 1'b1;
          state_d            = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the winner into the output register and advance the round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q      <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= IDW'(N_REQ - 1);
    end else if (grant) begin
      out_q      <= win_req;
      grant_id_q <= win_idx;
      rr_ptr_q   <= win_idx;
    end
  end

  assign out_addr     = out_q.addr;
  assign out_length   = out_q.length;
  assign out_bdf      = out_q.bdf;
  assign out_wdata    = out_q.wdata;
  assign out_grant_id = grant_id_q;

endmodule

// File: tb/tb_tlp_wr_arbiter.sv
// Bench for tlp_wr_arbiter: directed scenarios then random traffic against a reference model.
// Expected output transactions are queued at grant time; a monitor compares whenever out_valid is high.
// Credit expectations follow TLP_ARB_CREDIT_CHECK_EN exactly as the design build does.
module tb_tlp_wr_arbiter;

  localparam int N       = 2;
  localparam int AW      = 32;
  localparam int DW      = 1024;
  localparam int CW      = 8;
  localparam int PH_INIT = 8;
  localparam int PD_INIT = 64;
`ifdef TLP_ARB_CREDIT_CHECK_EN
  localparam bit CREDIT_EN = 1'b1;
`else
  localparam bit CREDIT_EN = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [15:0]   bdf;
    logic [DW-1:0] wdata;
    int            id;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N-1:0]           req_valid, req_ready;
  logic [N*AW-1:0]        req_addr;
  logic [N*8-1:0]         req_length;
  logic [N*16-1:0]        req_bdf;
  logic [N*DW-1:0]        req_wdata;
  logic                   out_valid, out_ready;
  logic [AW-1:0]          out_addr;
  logic [7:0]             out_length;
  logic [15:0]            out_bdf;
  logic [DW-1:0]          out_wdata;
  logic [$clog2(N)-1:0]   out_grant_id;
  logic                   ph_credit_return;
  logic [CW-1:0]          pd_credit_return, ph_credit_avail, pd_credit_avail;

  logic [AW-1:0] ra [N];
  logic [7:0]    rl [N];
  logic [15:0]   rb [N];
  logic [DW-1:0] rw [N];

  // Reference model state
  bit   m_busy;
  int   m_rr, m_ph, m_pd;
  exp_t exp_q[$];
  int   n_chk, n_fail;

  always #5 clk = ~clk;

  always_comb begin
    req_addr   = '0;
    req_length = '0;
    req_bdf    = '0;
    req_wdata  = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]   = ra[i];
      req_length[i*8 +: 8]   = rl[i];
      req_bdf[i*16 +: 16]    = rb[i];
      req_wdata[i*DW +: DW]  = rw[i];
    end
  end

  tlp_wr_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CREDIT_WIDTH(CW),
    .PH_CREDIT_INIT(PH_INIT), .PD_CREDIT_INIT(PD_INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_length(req_length), .req_bdf(req_bdf), .req_wdata(req_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_length(out_length), .out_bdf(out_bdf), .out_wdata(out_wdata),
    .out_grant_id(out_grant_id),
    .ph_credit_return(ph_credit_return), .pd_credit_return(pd_credit_return),
    .ph_credit_avail(ph_credit_avail), .pd_credit_avail(pd_credit_avail)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int need_of(input int len);
    return (len + 3) / 4;
  endfunction

  task automatic new_req(input int i, input int len);
    ra[i] = $urandom();
    rl[i] = 8'(len);
    rb[i] = 16'($urandom());
    for (int w = 0; w < DW/32; w++) rw[i][w*32 +: 32] = $urandom();
    req_valid[i] = 1'b1;
  endtask

  // One clock cycle: predict, compare combinational/registered outputs, then advance the model.
  task automatic step();
    int   win;
    int   cand;
    int   wneed;
    logic [N-1:0] exp_rdy;
    exp_t e;
    @(negedge clk);
    win   = -1;
    wneed = 0;
    if (rst_n && !m_busy) begin
      for (int k = 1; k <= N; k++) begin
        cand = (m_rr + k) % N;
        if (win < 0 && req_valid[cand] &&
            (!CREDIT_EN || (m_ph >= 1 && m_pd >= need_of(int'(rl[cand])))))
          win = cand;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("req_ready", 256'(req_ready), 256'(exp_rdy));
    check("out_valid", 256'(out_valid), 256'(m_busy));
    check("ph_avail", 256'(ph_credit_avail), 256'(m_ph));
    check("pd_avail", 256'(pd_credit_avail), 256'(m_pd));
    if (win >= 0) begin
      e.addr  = ra[win];
      e.len   = rl[win];
      e.bdf   = rb[win];
      e.wdata = rw[win];
      e.id    = win;
      wneed   = need_of(int'(rl[win]));
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_rr   = N - 1;
      m_ph   = PH_INIT;
      m_pd   = PD_INIT;
      exp_q.delete();
    end else begin
      if (CREDIT_EN) begin
        m_ph = m_ph - ((win >= 0) ? 1 : 0) + int'(ph_credit_return);
        m_pd = m_pd - wneed + int'(pd_credit_return);
        if (m_ph > PH_INIT) m_ph = PH_INIT;
        if (m_pd > PD_INIT) m_pd = PD_INIT;
      end
      if (m_busy) begin
        if (out_ready) m_busy = 1'b0;
      end else if (win >= 0) begin
        m_busy         = 1'b1;
        m_rr           = win;
        req_valid[win] = 1'b0;
      end
    end
  endtask

  // Issue one request on requester i and run until it has been granted and accepted.
  task automatic serve(input int i, input int len);
    int c;
    new_req(i, len);
    c = 0;
    while ((req_valid[i] || m_busy) && c < 40) begin
      step();
      c++;
    end
    check("serve_done_in_budget", 256'(c < 40), 256'(1));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Monitor: whenever a request is presented, compare it with the oldest expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: out_valid with nothing outstanding at %0t", $time);
        end else begin
          e = exp_q[0];
          check("out_addr", 256'(out_addr), 256'(e.addr));
          check("out_length", 256'(out_length), 256'(e.len));
          check("out_bdf", 256'(out_bdf), 256'(e.bdf));
          check("out_grant_id", 256'(out_grant_id), 256'(e.id));
          for (int b = 0; b < DW/256; b++)
            check("out_wdata_beat", out_wdata[b*256 +: 256], e.wdata[b*256 +: 256]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    m_busy = 1'b0;
    m_rr = N - 1;
    m_ph = PH_INIT;
    m_pd = PD_INIT;
    rst_n = 1'b0;
    out_ready = 1'b0;
    ph_credit_return = 1'b0;
    pd_credit_return = '0;
    req_valid = '0;
    for (int i = 0; i < N; i++) new_req(i, 8);

    // Reset values while requests are pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_req_ready", 256'(req_ready), 256'(0));
    check("rst_out_addr", 256'(out_addr), 256'(0));
    check("rst_out_length", 256'(out_length), 256'(0));
    check("rst_out_bdf", 256'(out_bdf), 256'(0));
    check("rst_out_wdata", out_wdata[255:0], 256'(0));
    check("rst_grant_id", 256'(out_grant_id), 256'(0));
    check("rst_ph", 256'(ph_credit_avail), 256'(PH_INIT));
    check("rst_pd", 256'(pd_credit_avail), 256'(PD_INIT));
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b1;

    // First request: requester 0, addr 0x1000, len 32
    new_req(0, 32);
    ra[0] = 32'h1000;
    out_ready = 1'b1;
    step();
    step();
    check("tp1_pd", 256'(pd_credit_avail), 256'(CREDIT_EN ? 56 : 64));
    check("tp1_ph", 256'(ph_credit_avail), 256'(CREDIT_EN ? 7 : 8));

    // Both requesters continuously valid: grants alternate, one every two cycles
    ph_credit_return = 1'b1;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) if (!req_valid[i]) new_req(i, 8);
      step();
    end
    ph_credit_return = 1'b0;

    // Output held for 5 cycles: stable fields, no new grant
    for (int c = 0; c < 6 && (req_valid != '0 || m_busy); c++) step();
    for (int i = 0; i < N; i++) if (!req_valid[i]) new_req(i, 16);
    out_ready = 1'b0;
    step();
    repeat (5) step();
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (req_valid != '0 || m_busy); c++) step();

    // Credit starvation: pd = 4, big request skipped in favour of a small one
    reset_dut();
    ph_credit_return = 1'b1;
    for (int k = 0; k < 7; k++) serve(0, 32);
    serve(1, 16);
    ph_credit_return = 1'b0;
    new_req(0, 32);
    new_req(1, 8);
    step();
    check("starve_skip_pd", 256'(pd_credit_avail), 256'(CREDIT_EN ? 2 : 64));
    for (int c = 0; c < 10 && m_busy; c++) step();
    pd_credit_return = 8'd6;
    step();
    pd_credit_return = '0;
    for (int c = 0; c < 10 && (req_valid != '0 || m_busy); c++) step();
    check("starve_release", 256'(req_valid), 256'(0));

    // Grant and return in the same cycle, then clamping at the ceiling
    reset_dut();
    ph_credit_return = 1'b1;
    for (int k = 0; k < 6; k++) serve(0, 32);
    serve(0, 24);
    ph_credit_return = 1'b0;
    new_req(0, 32);
    pd_credit_return = 8'd5;
    step();
    pd_credit_return = '0;
    check("grant_and_return_pd", 256'(pd_credit_avail), 256'(CREDIT_EN ? 7 : 64));
    for (int c = 0; c < 10 && m_busy; c++) step();
    pd_credit_return = 8'd100;
    step();
    check("clamp_pd", 256'(pd_credit_avail), 256'(PD_INIT));
    step();
    check("clamp_pd_full", 256'(pd_credit_avail), 256'(PD_INIT));
    pd_credit_return = '0;

    // Reset while the output register is occupied
    new_req(0, 4);
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) if (!req_valid[i]) new_req(i, 12);
    out_ready = 1'b1;
    step();
    check("post_rst_grant0", 256'(m_rr), 256'(0));
    for (int c = 0; c < 20 && (req_valid != '0 || m_busy); c++) step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) new_req(i, $urandom_range(0, 32));
      out_ready        = ($urandom_range(0, 3) != 0);
      ph_credit_return = ($urandom_range(0, 2) == 0);
      pd_credit_return = ($urandom_range(0, 199) == 0) ? 8'd100 : 8'($urandom_range(0, 2));
      step();
    end

    // Drain
    out_ready = 1'b1;
    ph_credit_return = 1'b1;
    pd_credit_return = 8'd8;
    for (int c = 0; c < 200 && (req_valid != '0 || m_busy); c++) step();
    step();
    check("drained_queue", 256'(exp_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
